// File: rtl/execute_cycle.sv
// Execute stage of a five-stage RISC-V style pipeline: operand forwarding, ALU,
// branch resolution and the EX/MEM pipeline register.
module execute_cycle #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          RegWriteE,
    input  logic          ALUSrcE,
    input  logic          MemWriteE,
    input  logic          ResultSrcE,
    input  logic          BranchE,
    input  logic [2:0]    ALUControlE,
    input  logic [DW-1:0] RD1_E,
    input  logic [DW-1:0] RD2_E,
    input  logic [DW-1:0] Imm_Ext_E,
    input  logic [DW-1:0] PCE,
    input  logic [DW-1:0] PCPlus4E,
    input  logic [4:0]    RD_E,
    input  logic [DW-1:0] ResultW,
    input  logic [1:0]    ForwardA_E,
    input  logic [1:0]    ForwardB_E,
    input  logic          FlushE,
    output logic          PCSrcE,
    output logic [DW-1:0] PCTargetE,
    output logic          RegWriteM,
    output logic          MemWriteM,
    output logic          ResultSrcM,
    output logic [4:0]    RD_M,
    output logic [DW-1:0] PCPlus4M,
    output logic [DW-1:0] WriteDataM,
    output logic [DW-1:0] ALU_ResultM
);

    logic [DW-1:0] src_a;
    logic [DW-1:0] fwd_b;
    logic [DW-1:0] src_b;
    logic [DW-1:0] alu_result;
    logic          zero;

    // Forward select: 01 = writeback result, 10 = memory-stage ALU result.
    always_comb begin
        src_a = RD1_E;
        case (ForwardA_E)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALU_ResultM;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        fwd_b = RD2_E;
        case (ForwardB_E)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALU_ResultM;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

    always_comb begin
        alu_result = '0;
        case (ALUControlE)
            3'b000: alu_result = src_a + src_b;
            3'b001: alu_result = src_a - src_b;
            3'b010: alu_result = src_a & src_b;
            3'b011: alu_result = src_a | src_b;
            3'b100: alu_result = src_a ^ src_b;
            3'b101: alu_result = {{(DW-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            3'b110: alu_result = src_a << src_b[4:0];
            3'b111: alu_result = src_a >> src_b[4:0];
            default: alu_result = '0;
        endcase
    end

    assign zero      = (alu_result == '0);
    assign PCSrcE    = rst & BranchE & zero;
    assign PCTargetE = PCE + Imm_Ext_E;

    // Stores take the forwarded B operand, never the immediate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= '0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
        end else if (FlushE) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= '0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
        end else begin
            RegWriteM   <= RegWriteE;
            MemWriteM   <= MemWriteE;
            ResultSrcM  <= ResultSrcE;
            RD_M        <= RD_E;
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= fwd_b;
            ALU_ResultM <= alu_result;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: directed and random instructions, arithmetic reference
// model, expected M-stage contents queued per issue and popped by a monitor.
module tb_execute_cycle;

    localparam int EW = 104;

    logic        clk = 1'b0;
    logic        rst;
    logic        rw_e, alusrc_e, mw_e, rs_e, branch_e, flush_e;
    logic [2:0]  aluc_e;
    logic [31:0] rd1_e, rd2_e, imm_e, pce_e, pc4_e, result_w;
    logic [4:0]  rd_e;
    logic [1:0]  fa_e, fb_e;
    logic        pcsrc;
    logic [31:0] pctarget;
    logic        rw_m, mw_m, rs_m;
    logic [4:0]  rd_m;
    logic [31:0] pc4_m, wd_m, alu_m;

    logic [EW-1:0] exp_q[$];
    int            due_q[$];
    int            cyc = 0;
    int            n_pass = 0;
    int            n_total = 0;
    logic [31:0]   m_alu = '0;

    execute_cycle #(.DW(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(rw_e), .ALUSrcE(alusrc_e), .MemWriteE(mw_e), .ResultSrcE(rs_e),
        .BranchE(branch_e), .ALUControlE(aluc_e),
        .RD1_E(rd1_e), .RD2_E(rd2_e), .Imm_Ext_E(imm_e), .PCE(pce_e), .PCPlus4E(pc4_e),
        .RD_E(rd_e), .ResultW(result_w), .ForwardA_E(fa_e), .ForwardB_E(fb_e),
        .FlushE(flush_e), .PCSrcE(pcsrc), .PCTargetE(pctarget),
        .RegWriteM(rw_m), .MemWriteM(mw_m), .ResultSrcM(rs_m), .RD_M(rd_m),
        .PCPlus4M(pc4_m), .WriteDataM(wd_m), .ALU_ResultM(alu_m)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst) cyc <= cyc + 1;

    function automatic logic [EW-1:0] m_vec();
        return {rw_m, mw_m, rs_m, rd_m, pc4_m, wd_m, alu_m};
    endfunction

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] reg_val,
                                        input logic [31:0] w_val, input logic [31:0] m_val);
        if (sel == 2'd1) return w_val;
        if (sel == 2'd2) return m_val;
        return reg_val;
    endfunction

    // Arithmetic reference: wrapping via modulo 2^32, shifts as multiply/divide.
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint unsigned ua, ub, md, pw;
        int sa, sb;
        ua = 64'(a);
        ub = 64'(b);
        md = 64'h1_0000_0000;
        pw = 64'd1 << (ub % 32);
        sa = int'(a);
        sb = int'(b);
        case (op)
            3'd0: return 32'((ua + ub) % md);
            3'd1: return 32'((ua + md - ub) % md);
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return 32'((ua * pw) % md);
            default: return 32'(ua / pw);
        endcase
    endfunction

    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: each registered capture is compared with the oldest pending entry.
    always @(negedge clk) begin
        if (rst && due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            chk("m_stage", m_vec(), exp_q.pop_front());
        end
    end

    task automatic set_idle();
        rw_e = 0; alusrc_e = 0; mw_e = 0; rs_e = 0; branch_e = 0; flush_e = 0;
        aluc_e = 3'd0; rd1_e = '0; rd2_e = '0; imm_e = '0; pce_e = '0; pc4_e = '0;
        rd_e = '0; result_w = '0; fa_e = 2'd0; fb_e = 2'd0;
    endtask

    task automatic step();
        logic [31:0] a, fb, b, alu, tgt;
        logic        br;
        a   = fwd(fa_e, rd1_e, result_w, m_alu);
        fb  = fwd(fb_e, rd2_e, result_w, m_alu);
        b   = alusrc_e ? imm_e : fb;
        alu = ref_alu(aluc_e, a, b);
        tgt = 32'((64'(pce_e) + 64'(imm_e)) % 64'h1_0000_0000);
        br  = branch_e && (alu == 32'd0);
        #1;
        chk("pcsrc", EW'(pcsrc), EW'(br));
        chk("pctarget", EW'(pctarget), EW'(tgt));
        if (flush_e) exp_q.push_back('0);
        else exp_q.push_back({rw_e, mw_e, rs_e, rd_e, pc4_e, fb, alu});
        due_q.push_back(cyc + 1);
        m_alu = flush_e ? 32'd0 : alu;
        @(posedge clk);
        #1;
    endtask

    task automatic prime9();
        set_idle(); rd1_e = 32'd4; rd2_e = 32'd5; step();
    endtask

    initial begin
        rst = 1'b0;
        set_idle();
        rw_e = 1; mw_e = 1; rs_e = 1; branch_e = 1; rd_e = 5'd9;
        pc4_e = 32'h44; pce_e = 32'h40; imm_e = 32'h8;
        #3;
        chk("reset_m_async", m_vec(), '0);
        chk("reset_pcsrc", EW'(pcsrc), '0);
        repeat (2) @(posedge clk);
        #1 chk("reset_m_held", m_vec(), '0);
        @(negedge clk);
        #1 rst = 1'b1;
        step();

        // forwarding of operand A
        prime9(); set_idle(); rd1_e = 5; result_w = 7; rd2_e = 1; fa_e = 2'd1; step();
        prime9(); set_idle(); rd1_e = 5; result_w = 7; rd2_e = 1; fa_e = 2'd0; step();
        prime9(); set_idle(); rd1_e = 5; result_w = 7; rd2_e = 1; fa_e = 2'd2; step();

        // back-to-back dependency
        set_idle(); rd1_e = 3; rd2_e = 4; rd_e = 5'd2; rw_e = 1; step();
        set_idle(); fa_e = 2'd2; rd2_e = 1; aluc_e = 3'd1; step();

        // branch taken and not taken
        set_idle(); branch_e = 1; aluc_e = 3'd1; rd1_e = 32'h10; rd2_e = 32'h10;
        pce_e = 32'h100; imm_e = 32'h20; step();
        rd2_e = 32'h11; step();

        // ALU boundaries
        set_idle(); rd1_e = 32'hFFFF_FFFF; rd2_e = 1; step();
        set_idle(); aluc_e = 3'd5; rd1_e = 32'h8000_0000; rd2_e = 1; step();
        set_idle(); aluc_e = 3'd6; rd1_e = 1; alusrc_e = 1; imm_e = 32'h25; step();
        set_idle(); aluc_e = 3'd7; rd1_e = 32'h8000_0000; rd2_e = 31; step();

        // flush and store
        set_idle(); flush_e = 1; rw_e = 1; mw_e = 1; rd1_e = 32'h55; rd_e = 5'd7;
        pc4_e = 32'h88; step();
        set_idle(); mw_e = 1; alusrc_e = 1; imm_e = 32'h10; rd1_e = 32'h200;
        rd2_e = 32'h1111; result_w = 32'hCAFE_F00D; fb_e = 2'd1; step();

        // reset while an instruction is in flight
        set_idle(); rw_e = 1; mw_e = 1; rd1_e = 32'h77; rd_e = 5'd3; step();
        @(negedge clk);
        #1 rst = 1'b0;
        m_alu = '0;
        #1 chk("mid_reset_async", m_vec(), '0);
        @(posedge clk);
        #1 chk("mid_reset_held", m_vec(), '0);
        @(negedge clk);
        #1 rst = 1'b1;
        set_idle(); rw_e = 1; rd1_e = 32'h12; rd2_e = 32'h34; rd_e = 5'd4; pc4_e = 32'h8; step();

        for (int i = 0; i < 200; i++) begin
            rw_e = 1'($urandom); alusrc_e = 1'($urandom); mw_e = 1'($urandom);
            rs_e = 1'($urandom); branch_e = 1'($urandom); flush_e = ($urandom_range(0, 7) == 0);
            aluc_e = 3'($urandom); rd_e = 5'($urandom); fa_e = 2'($urandom); fb_e = 2'($urandom);
            rd1_e = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rd2_e = ($urandom_range(0, 3) == 0) ? rd1_e : $urandom;
            imm_e = $urandom; pce_e = $urandom; pc4_e = $urandom; result_w = $urandom;
            step();
        end

        set_idle();
        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 SHALL have parameter DW, default 32, datapath width in bits; only 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have control inputs RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE (1 bit each) and ALUControlE (3 bits), all from the decode/execute register.
REQ-005 SHALL have data inputs RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E (DW each) and RD_E (5 bits).
REQ-006 SHALL have input ResultW, DW bits: writeback-stage result, used as forwarding source 01.
REQ-007 SHALL have inputs ForwardA_E and ForwardB_E, 2 bits each, driven by the hazard unit.
REQ-008 SHALL have input FlushE, 1 bit: synchronous bubble-insert request.
REQ-009 SHALL have outputs PCSrcE (1 bit) and PCTargetE (DW), both combinational.
REQ-010 SHALL have registered outputs RegWriteM, MemWriteM, ResultSrcM (1 bit each), RD_M (5 bits), and PCPlus4M, WriteDataM, ALU_ResultM (DW each).

Function
REQ-011 SrcA SHALL be RD1_E for ForwardA_E=00, ResultW for 01, ALU_ResultM for 10, and RD1_E for 11.
REQ-012 The forwarded B value SHALL be selected from RD2_E, ResultW, or ALU_ResultM by ForwardB_E, using the same encoding as SrcA.
REQ-013 SrcB SHALL be Imm_Ext_E when ALUSrcE=1; otherwise it SHALL be the forwarded B value.
REQ-014 The ALU SHALL implement these ALUControlE codes: 000 add; 001 sub; 010 and; 011 or; 100 xor; 101 signed slt (result 1 or 0); 110 sll by SrcB[4:0]; 111 srl by SrcB[4:0].
REQ-015 Add and sub SHALL wrap modulo 2^32, with no carry or overflow output.
REQ-016 ZeroE SHALL be 1 exactly when the ALU result equals 0.
REQ-017 PCTargetE SHALL be PCE + Imm_Ext_E, wrapping modulo 2^32.
REQ-018 PCSrcE SHALL be BranchE AND ZeroE, and SHALL be forced to 0 while rst=0.
REQ-019 On each rising clk edge with rst=1 and FlushE=0, all M outputs SHALL capture their E-stage sources, giving a latency of 1 cycle.
REQ-020 WriteDataM SHALL capture the forwarded B value, not SrcB, so that stores receive forwarded data even when ALUSrcE=1.
REQ-021 On a rising edge with FlushE=1, RegWriteM and MemWriteM SHALL load 0, RD_M SHALL load 0, and the other M outputs SHALL load 0.
REQ-022 When FlushE and a valid instruction coincide, the flush SHALL take priority.
REQ-023 The stage SHALL have no stall input; the upstream register holds inputs stable when a stall is required.
REQ-024 RD_E=0 SHALL be passed through unchanged; suppressing forwarding from x0 is the hazard unit's job.

Reset
REQ-025 While rst=0, all registered outputs SHALL be 0 immediately, independent of clk.
REQ-026 On the first rising edge after rst is released, the M outputs SHALL capture normally.
REQ-027 Asserting rst mid-operation SHALL discard the in-flight instruction, with no partial write visible on RegWriteM or MemWriteM.

Verification
REQ-028 Reset: rst=0 with arbitrary inputs -> all M outputs are 0 and PCSrcE=0 without any clock edge; after release plus 1 edge, M outputs equal the previous E values.
REQ-029 Forwarding: RD1_E=5, ResultW=7, ALU_ResultM=9, RD2_E=1, ALUControlE=000, ALUSrcE=0 -> ForwardA_E 00/01/10 yields ALU_ResultM of 6, 8, 10 on the next cycle respectively.
REQ-030 Back-to-back dependency: cycle 1 computes 3+4 with RD_E=2, RegWriteE=1; cycle 2 uses ForwardA_E=10 with src2=1 and sub -> second result is 6.
REQ-031 Branch: BranchE=1, sub with SrcA=SrcB=0x10, PCE=0x100, Imm=0x20 -> PCSrcE=1 and PCTargetE=0x120; with SrcB=0x11 -> PCSrcE=0.
REQ-032 ALU boundaries: 0xFFFFFFFF+1 -> 0; slt of 0x80000000 vs 1 -> 1; sll of 1 by 0x25 -> 0x20; srl of 0x80000000 by 31 -> 1.
REQ-033 Flush and store: FlushE=1 with RegWriteE=1 and MemWriteE=1 -> next cycle RegWriteM=0 and MemWriteM=0; a store with ALUSrcE=1 and ForwardB_E=01 -> WriteDataM equals ResultW.
